soa_arbiter: RTL and testbench
==============================

SOA_ARBITER -- requirements
Module: soa_arbiter

Interface
REQ-001 Parameter LOG2_WIDTH, default 4: log2 of the linear operand width.
REQ-002 Parameter WIDTH, default 2**LOG2_WIDTH: linear operand width.
REQ-003 Parameter M, default 8: set-one adder parameter; the low M sum bits are forced to 1.
REQ-004 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-005 Derived width OPW = LOG2_WIDTH+WIDTH-1, the log-domain operand width.
REQ-006 Derived width IDW = clog2(NREQ), the requester-index width.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 en  in  1  grant enable; when low, no new grants, in-flight work drains.
REQ-010 req_valid  in  NREQ  per-requester operand-pair valid.
REQ-011 req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-012 req_op1, req_op2  in  NREQ*OPW  packed operands; requester i occupies bits [i*OPW +: OPW].
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accept.
REQ-015 out_x  out  WIDTH-1  fractional result.
REQ-016 out_k  out  LOG2_WIDTH+1  characteristic result.
REQ-017 out_id  out  IDW  index of the requester that owns the result.
REQ-018 op_count  out  16  count of completed results; wraps.
REQ-019 idle  out  1  high when no stage holds valid data.

Function
REQ-020 The block shall contain one shared SOA instance with LOG2_WIDTH, WIDTH and M passed through; its inputs are driven only from stage-A registers.
REQ-021 The SOA result shall be defined as:
- sum[M-1:0] = all ones;
- sum[OPW:M] = op1[OPW-1:M] + op2[OPW-1:M] + (op1[M-1] & op2[M-1]), with no truncation;
- x = sum[WIDTH-2:0]; k = sum[OPW:WIDTH-1].
REQ-022 Pipeline control signals shall be defined as:
- B_adv = !out_valid | out_ready;
- A_free = !a_valid | B_adv.
REQ-023 A grant shall occur in a cycle when en=1, A_free=1 and at least one req_valid bit is high.
REQ-024 The granted index shall be the first valid requester found scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-025 req_ready shall be combinational and equal to the one-hot grant; a transfer is req_valid[i] & req_ready[i].
REQ-026 On a grant, stage A shall load op1, op2 and the granted index, set a_valid, and set rr_ptr to (index+1) mod NREQ.
REQ-027 rr_ptr shall hold its value in cycles with no grant.
REQ-028 When a_valid & B_adv, the output register shall load the SOA x/k and stage-A id and set out_valid.
REQ-029 When B_adv=1 and stage A is empty, out_valid shall clear.
REQ-030 Latency shall be 2 cycles: a transfer at edge N gives out_valid at edge N+1 after the stage-A load, i.e. visible after edge N+1, and requester throughput shall be 1 result per cycle when out_ready is held high.
REQ-031 While out_valid=1 and out_ready=0, out_x, out_k, out_id and out_valid shall hold stable.
REQ-032 Under stall, stage A shall hold and no further grant shall occur.
REQ-033 Simultaneous output drain and stage-A refill in the same cycle shall be permitted without a bubble.
REQ-034 op_count shall increment by 1 on each out_valid & out_ready, wrapping 0xFFFF to 0x0000.
REQ-035 idle shall equal !a_valid & !out_valid.
REQ-036 Deasserting en mid-stream shall not drop, duplicate or reorder accepted operations.
REQ-037 Results shall emerge in grant order.

Reset
REQ-038 When rst_n=0, the block shall asynchronously clear a_valid, out_valid, rr_ptr, op_count, out_x, out_k, out_id and stage-A registers to 0, and hold req_ready at 0.
REQ-039 Reset asserted mid-operation shall discard all in-flight results, and no out_valid shall appear after release until a new grant.
REQ-040 After reset release, idle shall read 1 and the first grant shall go to the lowest-index valid requester.

Verification
REQ-041 Single op, req0: op1=0x00100, op2=0x00100, out_ready=1 -> after 2 edges out_valid=1, out_x=0x02FF, out_k=0, out_id=0, op_count=1.
REQ-042 Carry-in and carry-out: op1=0x7FF80, op2=0x00080 -> out_x=0x00FF, out_k=0x10; op1=op2=0x00080 -> out_x=0x01FF, out_k=0.
REQ-043 Fairness: all 4 req_valid held high with out_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and out_id follows the same order.
REQ-044 Backpressure: out_ready=0 for 5 cycles with 3 requesters pending -> exactly 2 operations accepted, outputs held stable; on release results drain in order with no loss.
REQ-045 Control corners: en=0 with requests pending -> req_ready=0 and the pipeline drains to idle=1; op_count preset to 0xFFFF plus one completion -> 0x0000; rst_n pulsed low with both stages full -> out_valid=0 immediately and idle=1.

Source files
------------

// File: rtl/soa_arbiter.sv
// Round-robin arbiter that feeds NREQ requesters into one shared set-one adder
// through a two-stage (operand register, result register) valid/ready pipeline.

module soa_add #(
  parameter int unsigned LOG2_WIDTH = 4,
  parameter int unsigned WIDTH      = 2**LOG2_WIDTH,
  parameter int unsigned M          = 8
) (
  input  logic [LOG2_WIDTH+WIDTH-2:0] op1,
  input  logic [LOG2_WIDTH+WIDTH-2:0] op2,
  output logic [WIDTH-2:0]            x_c,
  output logic [LOG2_WIDTH:0]         k_c
);
  localparam int unsigned OPW = LOG2_WIDTH + WIDTH - 1;
  localparam int unsigned HW  = OPW - M + 1;

  logic [HW-1:0] hi_c;
  logic [OPW:0]  sum_c;
  logic          unused_c;

  // Low M bits are forced to one; only their top bit pair feeds a carry upward.
  assign hi_c     = HW'(op1[OPW-1:M]) + HW'(op2[OPW-1:M]) + HW'(op1[M-1] & op2[M-1]);
  assign sum_c    = {hi_c, {M{1'b1}}};
  assign x_c      = sum_c[WIDTH-2:0];
  assign k_c      = sum_c[OPW:WIDTH-1];
  assign unused_c = ^{op1[M-2:0], op2[M-2:0]};
endmodule

module soa_arbiter #(
  parameter int unsigned LOG2_WIDTH = 4,
  parameter int unsigned WIDTH      = 2**LOG2_WIDTH,
  parameter int unsigned M          = 8,
  parameter int unsigned NREQ       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    en,
  input  logic [NREQ-1:0]                         req_valid,
  output logic [NREQ-1:0]                         req_ready,
  input  logic [NREQ*(LOG2_WIDTH+WIDTH-1)-1:0]    req_op1,
  input  logic [NREQ*(LOG2_WIDTH+WIDTH-1)-1:0]    req_op2,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [WIDTH-2:0]                        out_x,
  output logic [LOG2_WIDTH:0]                     out_k,
  output logic [$clog2(NREQ)-1:0]                 out_id,
  output logic [15:0]                             op_count,
  output logic                                    idle
);
  localparam int unsigned OPW = LOG2_WIDTH + WIDTH - 1;
  localparam int unsigned IDW = $clog2(NREQ);

  logic            b_adv_c, a_free_c, grant_c, found_c;
  logic [IDW-1:0]  gnt_id_c, scan_id_c, rr_ptr;
  logic            a_valid;
  logic [OPW-1:0]  a_op1, a_op2;
  logic [IDW-1:0]  a_id;
  logic [WIDTH-2:0]    soa_x_c;
  logic [LOG2_WIDTH:0] soa_k_c;

  assign b_adv_c  = !out_valid || out_ready;
  assign a_free_c = !a_valid || b_adv_c;
  assign grant_c  = en && a_free_c && (|req_valid);
  assign idle     = !a_valid && !out_valid;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_id_c  = '0;
    scan_id_c = '0;
    found_c   = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      scan_id_c = IDW'((32'(rr_ptr) + j) % NREQ);
      if (!found_c && req_valid[scan_id_c]) begin
        found_c  = 1'b1;
        gnt_id_c = scan_id_c;
      end
    end
  end

  assign req_ready = (rst_n && grant_c) ? (NREQ'(1) << gnt_id_c) : '0;

  soa_add #(
    .LOG2_WIDTH (LOG2_WIDTH),
    .WIDTH      (WIDTH),
    .M          (M)
  ) u_soa (
    .op1 (a_op1),
    .op2 (a_op2),
    .x_c (soa_x_c),
    .k_c (soa_k_c)
  );

  // Stage A refills on a grant; the result register advances whenever it can drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid   <= 1'b0;
      a_op1     <= '0;
      a_op2     <= '0;
      a_id      <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_k     <= '0;
      out_id    <= '0;
      op_count  <= '0;
    end else begin
      if (grant_c) begin
        a_valid <= 1'b1;
        a_op1   <= req_op1[gnt_id_c*OPW +: OPW];
        a_op2   <= req_op2[gnt_id_c*OPW +: OPW];
        a_id    <= gnt_id_c;
        rr_ptr  <= IDW'((32'(gnt_id_c) + 32'd1) % NREQ);
      end else if (b_adv_c) begin
        a_valid <= 1'b0;
      end
      if (b_adv_c) begin
        out_valid <= a_valid;
        if (a_valid) begin
          out_x  <= soa_x_c;
          out_k  <= soa_k_c;
          out_id <= a_id;
        end
      end
      if (out_valid && out_ready) begin
        op_count <= op_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_soa_arbiter.sv
// Directed bench for soa_arbiter: adder vectors, round-robin order, stall,
// enable gating, mid-flight reset and op_count wrap.
module tb_soa_arbiter;
  localparam int unsigned LW   = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned M    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned OPW  = LW + W - 1;
  localparam int unsigned IDW  = 2;

  logic                 clk, rst_n, en, out_valid, out_ready, idle;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*OPW-1:0]  req_op1, req_op2;
  logic [W-2:0]         out_x;
  logic [LW:0]          out_k;
  logic [IDW-1:0]       out_id;
  logic [15:0]          op_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_cnt;

  typedef struct {
    int             id;
    logic [OPW-1:0] op1;
    logic [OPW-1:0] op2;
    logic [W-2:0]   x;
    logic [LW:0]    k;
  } vec_t;
  vec_t vecs [6];

  logic [3:0] bp_ready [9];
  logic [3:0] bp_req   [9];
  logic       bp_valid [9];
  int         bp_id    [9];

  soa_arbiter #(.LOG2_WIDTH(LW), .WIDTH(W), .M(M), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_k     (out_k),
    .out_id    (out_id),
    .op_count  (op_count),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completed-handshake scoreboard count.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_cnt <= 32'd0;
    else if (out_valid && out_ready) exp_cnt <= exp_cnt + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    req_op1[i*OPW +: OPW] = a;
    req_op2[i*OPW +: OPW] = b;
  endtask

  function automatic logic [31:0] fx(input int j);
    return ((32'(j) + 32'd1) << 8) | 32'hFF;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 10 && !idle; c++) @(negedge clk);
    #1;
    check("drain_idle", 32'(idle), 32'd1);
  endtask

  task automatic single_op();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; req_valid = '0; out_ready = 1'b1;
    req_op1 = '0; req_op2 = '0;
    vecs[0] = '{0, 19'h00100, 19'h00100, 15'h02FF, 5'h00};
    vecs[1] = '{1, 19'h7FF80, 19'h00080, 15'h00FF, 5'h10};
    vecs[2] = '{2, 19'h00080, 19'h00080, 15'h01FF, 5'h00};
    vecs[3] = '{3, 19'h7FFFF, 19'h7FFFF, 15'h7FFF, 5'h1F};
    vecs[4] = '{1, 19'h12345, 19'h00000, 15'h23FF, 5'h02};
    vecs[5] = '{0, 19'h00000, 19'h00000, 15'h00FF, 5'h00};
    bp_ready = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    bp_req   = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    bp_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bp_id    = '{0, 0, 0, 0, 0, 0, 1, 3, 0};

    // Reset state, with requests present during reset.
    #2 rst_n = 1'b0; en = 1'b1; req_valid = '1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_count", 32'(op_count), 32'd0);
    check("rst_x", 32'(out_x), 32'd0);
    check("rst_k", 32'(out_k), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    @(negedge clk); req_valid = '0; rst_n = 1'b1;

    // Single-operation adder vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 4'(1) << vecs[i].id;
      set_op(vecs[i].id, vecs[i].op1, vecs[i].op2);
      #1;
      check("vec_ready", 32'(req_ready), 32'd1 << vecs[i].id);
      check("vec_count", 32'(op_count), 32'(i));
      @(negedge clk); req_valid = '0;
      @(negedge clk); #1;
      check("vec_valid", 32'(out_valid), 32'd1);
      check("vec_x", 32'(out_x), 32'(vecs[i].x));
      check("vec_k", 32'(out_k), 32'(vecs[i].k));
      check("vec_id", 32'(out_id), 32'(vecs[i].id));
    end

    // Round-robin fairness with back-to-back throughput.
    pulse_reset();
    for (int i = 0; i < 4; i++) set_op(i, OPW'((i + 1) << 8), '0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      check("rr_ready", 32'(req_ready), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      check("rr_valid", 32'(out_valid), 32'(c >= 2));
      if (c >= 2) begin
        check("rr_id", 32'(out_id), 32'((c - 2) % 4));
        check("rr_x", 32'(out_x), fx((c - 2) % 4));
      end
    end
    drain();

    // Backpressure: two accepted, held stable, then in-order drain.
    begin
      int acc;
      acc = 0;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        out_ready = (c >= 5);
        req_valid = bp_req[c];
        #1;
        if (c < 5) acc += $countones(req_valid & req_ready);
        check("bp_ready", 32'(req_ready), 32'(bp_ready[c]));
        check("bp_valid", 32'(out_valid), 32'(bp_valid[c]));
        if (bp_valid[c]) begin
          check("bp_id", 32'(out_id), 32'(bp_id[c]));
          check("bp_x", 32'(out_x), fx(bp_id[c]));
        end
      end
      check("bp_accepted", 32'(acc), 32'd2);
    end
    drain();

    // Enable low: no grants, pipeline drains.
    @(negedge clk); en = 1'b1; req_valid = 4'hF; #1;
    check("en_ready0", 32'(req_ready), 32'b0001);
    @(negedge clk); en = 1'b0; #1;
    check("en_ready1", 32'(req_ready), 32'd0);
    check("en_idle1", 32'(idle), 32'd0);
    @(negedge clk); #1;
    check("en_valid2", 32'(out_valid), 32'd1);
    check("en_id2", 32'(out_id), 32'd0);
    check("en_ready2", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check("en_valid3", 32'(out_valid), 32'd0);
    check("en_idle3", 32'(idle), 32'd1);
    check("en_ready3", 32'(req_ready), 32'd0);

    // Reset with both stages full.
    @(negedge clk); en = 1'b1; out_ready = 1'b0; #1;
    check("mr_ready0", 32'(req_ready), 32'b0010);
    @(negedge clk); #1;
    check("mr_ready1", 32'(req_ready), 32'b0100);
    @(negedge clk); #1;
    check("mr_full_valid", 32'(out_valid), 32'd1);
    check("mr_full_idle", 32'(idle), 32'd0);
    check("mr_stall_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0; #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_idle", 32'(idle), 32'd1);
    check("mr_ready", 32'(req_ready), 32'd0);
    check("mr_count", 32'(op_count), 32'd0);
    @(negedge clk); rst_n = 1'b1; req_valid = '0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check("mr_no_ghost", 32'(out_valid), 32'd0);
    end
    @(negedge clk); req_valid = 4'b1100; #1;
    check("mr_first_grant", 32'(req_ready), 32'b0100);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    check("mr_out_valid", 32'(out_valid), 32'd1);
    check("mr_out_id", 32'(out_id), 32'd2);
    drain();

    // op_count wrap: stream to 0xFFFF, then one more completion.
    en = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 70000 && exp_cnt < 32'hFFFD; c++) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("cnt_track", 32'(op_count), 32'(exp_cnt[15:0]));
    for (int g = 0; g < 8 && exp_cnt < 32'hFFFF; g++) single_op();
    #1;
    check("cnt_ffff", 32'(op_count), 32'h0000FFFF);
    single_op();
    #1;
    check("cnt_wrap", 32'(op_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
